// File: rtl/aes_round_sched.sv
// Iterative AES-128 sequencer: holds the cipher state, round key and round counter,
// and steps one external combinational round datapath through all NR rounds.
module aes_round_sched #(
  parameter int NR       = 10,
  parameter int RND_WAIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] pt_i,
  input  logic [127:0] key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] ct_o,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         rnd_start_o,
  output logic [3:0]   rnd_rc_o,
  output logic [127:0] rnd_data_o,
  output logic [127:0] rnd_key_o,
  input  logic [127:0] rnd_out_i,
  input  logic [127:0] rnd_key_i,
  input  logic [127:0] fin_out_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [3:0] PEN_RND  = 4'(NR - 1);
  localparam logic [2:0] WAIT_MAX = 3'(RND_WAIT);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [2:0]   wait_q, wait_d;
  logic         settled;

  // The datapath result is only trusted once the multicycle settle budget is spent.
  assign settled = !(wait_q < WAIT_MAX);

  assign rnd_data_o = state_q;
  assign rnd_key_o  = key_q;
  assign rnd_rc_o   = rnd_q;
  assign ct_o       = ct_q;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    ct_d        = ct_q;
    rnd_d       = rnd_q;
    wait_d      = wait_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    rnd_start_o = 1'b0;

    case (fsm_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (!abort_i && in_valid_i) begin
          state_d = pt_i ^ key_i;
          key_d   = key_i;
          rnd_d   = 4'd1;
          wait_d  = 3'd0;
          fsm_d   = ROUND;
        end
      end

      ROUND: begin
        rnd_start_o = 1'b1;
        if (abort_i) begin
          fsm_d  = IDLE;
          rnd_d  = 4'd0;
          wait_d = 3'd0;
        end else if (!settled) begin
          wait_d = wait_q + 3'd1;
        end else begin
          state_d = rnd_out_i;
          key_d   = rnd_key_i;
          wait_d  = 3'd0;
          if (rnd_q == PEN_RND) begin
            rnd_d = LAST_RND;
            fsm_d = FINAL;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end

      FINAL: begin
        rnd_start_o = 1'b1;
        if (abort_i) begin
          fsm_d  = IDLE;
          rnd_d  = 4'd0;
          wait_d = 3'd0;
        end else if (!settled) begin
          wait_d = wait_q + 3'd1;
        end else begin
          ct_d   = fin_out_i;
          wait_d = 3'd0;
          fsm_d  = DONE;
        end
      end

      DONE: begin
        out_valid_o = 1'b1;
        // Abort and a completed handshake both land in IDLE; abort simply takes precedence.
        if (abort_i || out_ready_i) begin
          fsm_d = IDLE;
          rnd_d = 4'd0;
        end
      end

      default: begin
        fsm_d  = IDLE;
        rnd_d  = 4'd0;
        wait_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      rnd_q   <= '0;
      wait_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      rnd_q   <= rnd_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: wraps a behavioural AES round/key-expansion datapath
// around two sequencer instances (RND_WAIT=0 and RND_WAIT=2) and scoreboards ciphertexts.
module tb_aes_round_sched;

  localparam int NR   = 10;
  localparam int LAT1 = 1 + NR * (0 + 1);
  localparam int LAT2 = 1 + NR * (2 + 1);

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, abort, busy, rnd_start;
  logic [127:0] pt, key, ct, rnd_data, rnd_key, rnd_out, rk_nx, fin_out, sr;
  logic [3:0]   rnd_rc;
  logic         in_valid2, in_ready2, out_valid2, out_ready2, abort2, busy2, rnd_start2;
  logic [127:0] pt2, key2, ct2, rnd_data2, rnd_key2, rnd_out2, rk_nx2, fin_out2, sr2;
  logic [3:0]   rnd_rc2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise = 0;
  int rise_gap = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp2_q[$];
  int acc_q[$];
  int acc2_q[$];

  // ---------------- behavioural AES round datapath ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x; r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] bget(input logic [127:0] v, input int i);
    return v[127 - 8 * i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = sbox(bget(v, 4 * ((c + r) % 4) + r));
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = bget(v, 4 * c); a1 = bget(v, 4 * c + 1);
      a2 = bget(v, 4 * c + 2); a3 = bget(v, 4 * c + 3);
      o[127 - 32 * c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                               gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] rc);
    logic [7:0]  rcon;
    logic [31:0] t, w3, n0, n1, n2, n3;
    rcon = 8'h01;
    for (int i = 1; i < int'(rc); i++) rcon = gmul(rcon, 8'h02);
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign rk_nx    = key_exp(rnd_key, rnd_rc);
  assign sr       = sub_shift(rnd_data);
  assign rnd_out  = mix(sr) ^ rk_nx;
  assign fin_out  = sr ^ rk_nx;
  assign rk_nx2   = key_exp(rnd_key2, rnd_rc2);
  assign sr2      = sub_shift(rnd_data2);
  assign rnd_out2 = mix(sr2) ^ rk_nx2;
  assign fin_out2 = sr2 ^ rk_nx2;

  aes_round_sched #(.NR(NR), .RND_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pt_i(pt), .key_i(key), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ct_o(ct), .abort_i(abort), .busy_o(busy), .rnd_start_o(rnd_start),
    .rnd_rc_o(rnd_rc), .rnd_data_o(rnd_data), .rnd_key_o(rnd_key),
    .rnd_out_i(rnd_out), .rnd_key_i(rk_nx), .fin_out_i(fin_out)
  );

  aes_round_sched #(.NR(NR), .RND_WAIT(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .pt_i(pt2), .key_i(key2), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .ct_o(ct2), .abort_i(abort2), .busy_o(busy2), .rnd_start_o(rnd_start2),
    .rnd_rc_o(rnd_rc2), .rnd_data_o(rnd_data2), .rnd_key_o(rnd_key2),
    .rnd_out_i(rnd_out2), .rnd_key_i(rk_nx2), .fin_out_i(fin_out2)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic chkn(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_v, prev_v2;
    prev_v = 1'b0; prev_v2 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && !prev_v) begin
          if (acc_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_valid: got out_valid=1 required 0 (no job pending)");
          end else begin
            chkn("latency", cyc - acc_q.pop_front(), LAT1);
          end
          rise_gap = cyc - last_rise;
          last_rise = cyc;
        end
        if (out_valid && out_ready && !abort) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ct: got %h required no output", ct);
          end else begin
            check("ct", ct, exp_q.pop_front());
          end
        end
        if (in_valid && in_ready && !abort) acc_q.push_back(cyc);

        if (out_valid2 && !prev_v2) begin
          if (acc2_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_valid_w2: got out_valid=1 required 0");
          end else begin
            chkn("latency_w2", cyc - acc2_q.pop_front(), LAT2);
          end
        end
        if (out_valid2 && out_ready2 && !abort2) begin
          if (exp2_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ct_w2: got %h required no output", ct2);
          end else begin
            check("ct_w2", ct2, exp2_q.pop_front());
          end
        end
        if (in_valid2 && in_ready2 && !abort2) acc2_q.push_back(cyc);
      end
      prev_v = out_valid;
      prev_v2 = out_valid2;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_job(input logic [127:0] p, input logic [127:0] k,
                           input logic [127:0] c, input bit hold);
    int n;
    pt = p; key = k; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chkn("accept_timeout", int'(in_ready), 1);
    exp_q.push_back(c);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chkn("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_rc(input logic [3:0] r);
    int n;
    n = 0;
    while (!(rnd_start && rnd_rc == r) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chkn("reach_round", int'(rnd_rc), int'(r));
  endtask

  initial begin
    int n, vcount;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0; pt = '0; key = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; abort2 = 1'b0; pt2 = '0; key2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chkn("rst_in_ready", int'(in_ready), 1);
    chkn("rst_out_valid", int'(out_valid), 0);
    chkn("rst_busy", int'(busy), 0);
    chkn("rst_rnd_start", int'(rnd_start), 0);
    chkn("rst_rc", int'(rnd_rc), 0);
    check("rst_ct", ct, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // C.1 with round-number trace
    start_job(P_C1, K_C1, C_C1, 1'b0);
    for (int i = 1; i <= NR; i++) begin
      chkn("rc_seq", int'(rnd_rc), i);
      chkn("start_hi", int'(rnd_start), 1);
      @(posedge clk); #1;
    end
    wait_drain();

    // App. B
    start_job(P_B, K_B, C_B, 1'b0);
    wait_drain();

    // Backpressure in DONE
    out_ready = 1'b0;
    start_job(P_B, K_B, C_B, 1'b0);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; pt = {4{$urandom}}; key = {4{$urandom}};
    for (int i = 0; i < 20; i++) begin
      chkn("bp_valid", int'(out_valid), 1);
      check("bp_ct_stable", ct, C_B);
      chkn("bp_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chkn("bp_release_idle", int'(in_ready), 1);
    chkn("bp_release_valid", int'(out_valid), 0);
    chkn("bp_drained", exp_q.size(), 0);

    // Back-to-back with in_valid and out_ready held high
    start_job(P_C1, K_C1, C_C1, 1'b1);
    start_job(P_B, K_B, C_B, 1'b0);
    wait_drain();
    chkn("b2b_period", rise_gap, 12);

    // Abort at round 5
    start_job(P_C1, K_C1, C_C1, 1'b0);
    wait_rc(4'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chkn("abort_busy", int'(busy), 0);
    chkn("abort_in_ready", int'(in_ready), 1);
    chkn("abort_start", int'(rnd_start), 0);
    chkn("abort_rc", int'(rnd_rc), 0);
    exp_q.delete(); acc_q.delete();
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) vcount++;
      @(posedge clk); #1;
    end
    chkn("abort_no_valid", vcount, 0);
    start_job(P_C1, K_C1, C_C1, 1'b0);
    wait_drain();

    // Reset during FINAL
    start_job(P_B, K_B, C_B, 1'b0);
    wait_rc(4'(NR));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chkn("frst_valid", int'(out_valid), 0);
    chkn("frst_in_ready", int'(in_ready), 1);
    chkn("frst_busy", int'(busy), 0);
    chkn("frst_start", int'(rnd_start), 0);
    chkn("frst_rc", int'(rnd_rc), 0);
    check("frst_ct", ct, '0);
    check("frst_data", rnd_data, '0);
    check("frst_key", rnd_key, '0);
    rst_n = 1'b1;
    exp_q.delete(); acc_q.delete();
    @(posedge clk); #1;
    start_job(P_C1, K_C1, C_C1, 1'b0);
    wait_drain();

    // App. B on the RND_WAIT=2 instance
    pt2 = P_B; key2 = K_B; in_valid2 = 1'b1;
    chkn("w2_ready", int'(in_ready2), 1);
    exp2_q.push_back(C_B);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n = 0;
    while (exp2_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chkn("w2_drain_pending", exp2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
Iterative AES-128 encryption sequencer that time-multiplexes one combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus key expansion) over all rounds of a block. It performs the initial AddRoundKey and holds the state and round key in registers. It drives round counter `rc` to the datapath, selects a no-MixColumns final-round result for the last round, and presents the ciphertext on a valid/ready output. It sits between the AES peripheral register interface and the round datapath.

Parameters:
- NR, 10, number of rounds (AES-128); legal 2..15.
- RND_WAIT, 0, extra settle cycles per round before capture (multicycle-path budget); legal 0..7.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  plaintext/key valid
- in_ready_o  out  1  block can accept new job
- pt_i  in  128  plaintext
- key_i  in  128  cipher key
- out_valid_o  out  1  ciphertext valid
- out_ready_i  in  1  consumer accepts ciphertext
- ct_o  out  128  ciphertext
- abort_i  in  1  synchronous job cancel
- busy_o  out  1  job in progress (state != IDLE)
- rnd_start_o  out  1  start strobe to round datapath (high in ROUND/FINAL)
- rnd_rc_o  out  4  round number to datapath/key expansion
- rnd_data_o  out  128  current state to datapath
- rnd_key_o  out  128  current round key to datapath
- rnd_out_i  in  128  full-round result (MixColumns included) from datapath
- rnd_key_i  in  128  next round key from datapath
- fin_out_i  in  128  final-round result (no MixColumns, XOR with rnd_key_i)

Behaviour:
- Reset is synchronous, active-low, on the rising edge of clk with rst_n=0.
  - Reset forces state IDLE; in_ready_o=1, out_valid_o=0, busy_o=0, rnd_start_o=0.
  - Reset clears rnd_rc_o, ct_o, state_q, key_q, rnd_q and wait_q to 0.
  - Reset mid-job discards the job with no output.
- rnd_data_o=state_q, rnd_key_o=key_q, rnd_rc_o=rnd_q at all times (registered sources, no combinational paths from inputs).
- in_ready_o=1 only in IDLE.
- State IDLE:
  - On in_valid_i & in_ready_o: state_q<=pt_i^key_i, key_q<=key_i, rnd_q<=1, wait_q<=0, go to ROUND.
- State ROUND (rnd_q in 1..NR-1), rnd_start_o=1:
  - If wait_q<RND_WAIT: wait_q++.
  - Otherwise capture: state_q<=rnd_out_i, key_q<=rnd_key_i, wait_q<=0.
    - If rnd_q==NR-1: rnd_q<=NR and go to FINAL.
    - Otherwise: rnd_q++.
- State FINAL (rnd_q==NR), rnd_start_o=1:
  - Same wait rule as ROUND.
  - On capture: ct_q<=fin_out_i, go to DONE.
- State DONE, out_valid_o=1:
  - ct_o is stable while out_valid_o=1 and out_ready_i=0.
  - On out_ready_i: go to IDLE, rnd_q<=0.
  - A new job cannot be accepted in the same cycle as the DONE handshake; it is accepted earliest one cycle later.
- Latency: out_valid_o rises 1+NR*(RND_WAIT+1) cycles after the acceptance edge. This is 11 cycles at defaults.
- Throughput: one block per 2+NR*(RND_WAIT+1) cycles with out_ready_i held high.
- abort_i:
  - In any non-IDLE state, forces IDLE on the next edge: out_valid_o=0, rnd_start_o=0, rnd_q=0. ct_o keeps its last value.
  - In IDLE, abort_i has priority over in_valid_i; no accept occurs that cycle.
- Simultaneous abort_i and out_ready_i in DONE: abort wins. Result is identical (IDLE), but the output handshake is counted as not completed.
- in_valid_i / pt_i / key_i changes outside IDLE are ignored; inputs are sampled only at acceptance.
- out_ready_i is ignored outside DONE.
- Illegal state encodings recover to IDLE.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, bench wraps real round + final-round datapaths.
  - ct_o=69c4e0d86a7b0430d8cdb78070b4c55a.
  - out_valid_o exactly 11 cycles after accept.
  - rnd_rc_o sequence 1..10.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - ct 3925841d02dc09fbdc118597196a0b32.
  - Repeat with RND_WAIT=2: valid after 31 cycles, same ct.
- Backpressure: hold out_ready_i=0 for 20 cycles in DONE.
  - out_valid_o stays 1, ct_o stable, in_ready_o=0, in_valid_i ignored.
  - Release: IDLE next cycle.
- Back-to-back jobs with in_valid_i and out_ready_i held high: two C.1/App.B jobs produce both correct ciphertexts at a 12-cycle period.
- Abort at round 5 (rnd_rc_o=5):
  - Next cycle IDLE, busy_o=0, no out_valid_o.
  - A following C.1 job still yields 69c4e0d8….
- Reset (rst_n=0 one cycle) during FINAL: all outputs at reset values next cycle, no out_valid_o. Then a normal job completes correctly.
